spart_rx: RTL and testbench
===========================

// Module: spart_rx
// PURPOSE
//  Serial receive half of the SPART: recovers 8N1 asynchronous frames from rxd
//  using the 16x oversample enable produced by the SPART baud down-counter.
//  Holds the last received byte for the processor-side databus read and flags
//  rda, framing error and overrun. Sits beside the transmitter inside spart.
// PARAMETERS
//  DATA_BITS   8   payload bits per frame, LSB first
//  OVERSAMPLE  16  baud enable pulses per bit period
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  asynchronous reset, active-low
//  baud_r_enable  in   1  one-clk pulse, OVERSAMPLE per bit period
//  rxd            in   1  serial input, idle high, asynchronous to clk
//  rd_en          in   1  processor read of receive buffer (iocs & iorw & ioaddr==2'b00)
//  rx_data        out  8  last good received byte
//  rda            out  1  receive data available
//  frame_err      out  1  last frame had stop bit == 0
//  overrun        out  1  a byte was overwritten before being read
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE, counters=0, rx_data=8'h00, rda=0,
//    frame_err=0, overrun=0, synchronizer flops=1, armed=1.
//  - rxd passes a 2-flop synchronizer -> rxd_s; FSM uses rxd_s only.
//  - FSM and tick_cnt (4b) / bit_cnt (3b) advance only on cycles with
//    baud_r_enable==1; otherwise all hold.
//  - IDLE: armed=1 if rxd_s==1. If armed and rxd_s==0 -> START, tick_cnt=0.
//  - START: on tick_cnt==7 (mid start bit): rxd_s==0 -> DATA, tick_cnt=0,
//    bit_cnt=0; rxd_s==1 -> false start, back to IDLE, nothing flagged.
//  - DATA: on tick_cnt==15 shift rxd_s in at MSB (shift right, LSB first),
//    tick_cnt=0, bit_cnt++; after bit_cnt==DATA_BITS-1 sampled -> STOP.
//  - STOP: on tick_cnt==15 sample stop bit, -> IDLE:
//    rxd_s==1: rx_data<=shift reg, rda<=1, frame_err<=0; overrun<=1 if rda
//      already 1 and rd_en not asserted this cycle.
//    rxd_s==0: frame_err<=1, rx_data/rda unchanged, armed<=0 (line must
//      return high before next start; break never retriggers).
//  - Latency: rda/rx_data update on the clk edge of the stop-sample tick;
//    stop sample lands ~9.5 bit times after start-bit falling edge (+2 clk sync).
//  - rd_en: next edge rda<=0, overrun<=0; rx_data held; frame_err held.
//  - rd_en coincident with good-frame completion: completion wins, rda=1,
//    rx_data=new byte, overrun=0.
//  - rd_en while rda==0: no effect.
//  - Synchronous effect of rst mid-frame: n/a (async) -> partial frame dropped, FSM IDLE.
// STRUCTURE
//  - Shared header spart_defs.vh: FSM state localparams (IDLE/START/DATA/STOP,
//    2b), OVERSAMPLE midpoint/end constants, ioaddr decode values.
//  - One sub-module: spart_sync2 (2-flop synchronizer, reset value param).
//  - Top-level spart drives rda, muxes rx_data onto databus on read of addr 00.
// TESTING (bench: baud_r_enable every 4 clk, bit period = 64 clk)
//  1. Frame 0x55, stop=1 -> rx_data=8'h55, rda=1 at stop sample; frame_err=0.
//  2. After 1, pulse rd_en -> rda=0 next edge, rx_data still 8'h55.
//  3. rxd low for 4 ticks then high -> state back IDLE, rda=0, no flags.
//  4. Frame 0xA5 with stop=0 -> frame_err=1, rda=0, rx_data unchanged; line
//     held low 3 bit times then 0x3C sent -> only 0x3C received, frame_err=0.
//  5. 0x12 then 0x34 back-to-back, no read -> rx_data=8'h34, rda=1, overrun=1;
//     rd_en on 0x34 completion cycle instead -> overrun=0, rda=1.
//  6. Assert rst low mid-DATA of 0xFF -> all outputs reset; next frame 0xC3
//     received correctly, rda=1.

Source files
------------

// File: rtl/spart_rx_pkg.sv
// Shared constants, FSM state type and receive-status payload for the SPART receiver.
package spart_rx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  // Mid start bit and end of a full bit period, counted in oversample ticks
  localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] END_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;
  } rx_status_t;

endpackage

// File: rtl/spart_rx_if.sv
// Serial-line, baud-enable and processor-side read signals of the SPART receiver.
interface spart_rx_if;
  import spart_rx_pkg::*;

  logic                 baud_r_enable;
  logic                 rxd;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output baud_r_enable, rxd, rd_en,
    input  rx_data, rda, frame_err, overrun
  );

  modport slave (
    input  baud_r_enable, rxd, rd_en,
    output rx_data, rda, frame_err, overrun
  );

endinterface

// File: rtl/spart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module spart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: recovers 8N1 frames from rxd on a 16x oversample enable and
// holds the last byte with rda / frame_err / overrun status for the processor.
module spart_rx
  import spart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  spart_rx_if.slave  bus
);

  logic                 rxd_s;
  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  rx_status_t           stat_q, stat_d;

  // Idle-high line, so the synchronizer resets to 1 to avoid a phantom start edge
  spart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    stat_d  = stat_q;

    // Processor read; a completing good frame below overrides this in the same cycle
    if (bus.rd_en && stat_q.rda) begin
      stat_d.rda     = 1'b0;
      stat_d.overrun = 1'b0;
    end

    if (bus.baud_r_enable) begin
      case (state_q)
        IDLE: begin
          if (rxd_s) begin
            armed_d = 1'b1;
          end
          if (armed_q && !rxd_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == MID_TICK) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_q == END_TICK) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_q == END_TICK) begin
            state_d = IDLE;
            tick_d  = '0;
            if (rxd_s) begin
              stat_d.data      = shift_q;
              stat_d.rda       = 1'b1;
              stat_d.frame_err = 1'b0;
              stat_d.overrun   = bus.rd_en ? 1'b0 : (stat_q.overrun | stat_q.rda);
            end else begin
              // Break or framing error: wait for the line to go high before re-arming
              stat_d.frame_err = 1'b1;
              armed_d          = 1'b0;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_data   = stat_q.data;
  assign bus.rda       = stat_q.rda;
  assign bus.frame_err = stat_q.frame_err;
  assign bus.overrun   = stat_q.overrun;

endmodule

// File: tb/tb_spart_rx.sv
// Directed and randomized frame bench for spart_rx against a frame-level status model.
module tb_spart_rx;
  import spart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spart_rx_if bus();

  spart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned phase    = 0;

  // Frame-level model of the processor-visible status
  logic [7:0] m_data;
  logic       m_rda;
  logic       m_ferr;
  logic       m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"}, 32'(bus.rx_data),   32'(m_data));
    check({tag, "_rda"},  32'(bus.rda),       32'(m_rda));
    check({tag, "_ferr"}, 32'(bus.frame_err), 32'(m_ferr));
    check({tag, "_ovr"},  32'(bus.overrun),   32'(m_ovr));
  endtask

  // One clock; baud enable is high for every fourth rising edge (bit = 64 clk)
  task automatic step();
    @(negedge clk);
    phase = (phase + 1) % 4;
    bus.baud_r_enable = (phase == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd_pulse();
    step();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    if (m_rda) begin
      m_rda = 1'b0;
      m_ovr = 1'b0;
    end
    check_outputs("read");
  endtask

  task automatic false_start();
    do step(); while (phase != 2);
    bus.rxd = 1'b0;
    idle(16);
    bus.rxd = 1'b1;
    idle(80);
    check_outputs("false_start");
  endtask

  // Frame start is aligned so the synchronized falling edge meets a baud tick;
  // the stop sample then lands on the edge 610 clk (9.5 bits + 2) after the fall.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_coinc,
                            input int tail_low, input int rst_at);
    logic [9:0] bits;
    bit         aborted;
    int         last;
    bits    = {stop, b, 1'b0};
    aborted = 1'b0;
    last    = 640 + 64 * tail_low;
    do step(); while (phase != 2);
    bus.rxd = 1'b0;
    for (int rel = 1; rel <= last; rel++) begin
      step();
      if (rel < 640)       bus.rxd = bits[4'(rel / 64)];
      else if (rel < last) bus.rxd = 1'b0;
      else                 bus.rxd = 1'b1;
      if (rst_at != 0 && rel == rst_at) begin
        rst     = 1'b0;
        aborted = 1'b1;
      end
      if (rst_at != 0 && rel == rst_at + 1) begin
        m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_outputs("async_rst");
      end
      if (rst_at != 0 && rel == rst_at + 2) rst = 1'b1;
      if (rel == 610 && !aborted) begin
        check("pre_stop_rda", 32'(bus.rda), 32'(m_rda));
        if (rd_coinc) bus.rd_en = 1'b1;
      end
      if (rel == 611 && !aborted) begin
        bus.rd_en = 1'b0;
        if (stop) begin
          m_ovr  = rd_coinc ? 1'b0 : (m_ovr | m_rda);
          m_rda  = 1'b1;
          m_data = b;
          m_ferr = 1'b0;
        end else begin
          m_ferr = 1'b1;
          if (rd_coinc && m_rda) begin
            m_rda = 1'b0;
            m_ovr = 1'b0;
          end
        end
        check_outputs("frame");
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         mode;

    bus.rxd           = 1'b1;
    bus.rd_en         = 1'b0;
    bus.baud_r_enable = 1'b0;
    rst               = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    idle(3);
    check_outputs("reset");
    rst = 1'b1;
    idle(20);

    send_frame(8'h55, 1'b1, 1'b0, 0, 0);
    rd_pulse();
    false_start();

    send_frame(8'hA5, 1'b0, 1'b0, 3, 0);
    idle(64);
    check_outputs("break_hold");
    send_frame(8'h3C, 1'b1, 1'b0, 0, 0);

    rd_pulse();
    send_frame(8'h12, 1'b1, 1'b0, 0, 0);
    send_frame(8'h34, 1'b1, 1'b0, 0, 0);
    rd_pulse();
    send_frame(8'h12, 1'b1, 1'b0, 0, 0);
    send_frame(8'h34, 1'b1, 1'b1, 0, 0);

    send_frame(8'hFF, 1'b1, 1'b0, 0, 300);
    idle(64);
    check_outputs("post_rst");
    send_frame(8'hC3, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      rb   = 8'($urandom);
      rs   = ($urandom_range(0, 4) != 0);
      mode = int'($urandom_range(0, 2));
      if (mode == 1) rd_pulse();
      send_frame(rb, rs, mode == 2, 0, 0);
      idle(int'($urandom_range(0, 40)));
    end
    rd_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
